// File: rtl/alu_seq_core_pkg.sv
// Shared types for the sequential ALU: opcode encoding, flag bundle and FSM states.
package alu_seq_core_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_MULT   = 4'd2,
      OP_DIV    = 4'd3,
      OP_MOD    = 4'd4,
      OP_AND    = 4'd5,
      OP_OR     = 4'd6,
      OP_XOR    = 4'd7,
      OP_LSHIFT = 4'd8,
      OP_RSHIFT = 4'd9
   } OpCode;

   typedef struct packed {
      logic z;
      logic nf;
      logic v;
      logic c;
   } alu_flags_t;

   typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, FIX, DONE} alu_state_t;

endpackage

// File: rtl/alu_seq_core_div_iter.sv
// Restoring unsigned divider: loads on start, one quotient bit per cycle, pulses done
// after N iterations. quotient/remainder hold until the next start.
module div_iter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder
);
   localparam int SHIFT_W = $clog2(N) + 1;
   localparam logic [SHIFT_W-1:0] CNT_LAST = SHIFT_W'(N - 1);

   logic [N-1:0]       quo_reg, rem_reg, div_reg;
   logic [SHIFT_W-1:0] cnt_reg;
   logic               busy_reg, done_reg;
   logic [N:0]         partial;
   logic [N-1:0]       rem_sub;
   logic               fits;

   // Partial remainder is always below the divisor, so the difference fits in N bits.
   always_comb begin
      partial = {rem_reg, quo_reg[N-1]};
      fits    = (partial >= {1'b0, div_reg});
      rem_sub = partial[N-1:0] - div_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_reg  <= '0;
         rem_reg  <= '0;
         div_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else if (start) begin
         quo_reg  <= dividend;
         rem_reg  <= '0;
         div_reg  <= divisor;
         cnt_reg  <= '0;
         busy_reg <= 1'b1;
         done_reg <= 1'b0;
      end else if (busy_reg) begin
         rem_reg <= fits ? rem_sub : partial[N-1:0];
         quo_reg <= {quo_reg[N-2:0], fits};
         cnt_reg <= cnt_reg + SHIFT_W'(1);
         if (cnt_reg == CNT_LAST) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
         end
      end else begin
         done_reg <= 1'b0;
      end
   end

   assign done      = done_reg;
   assign quotient  = quo_reg;
   assign remainder = rem_reg;

endmodule

// File: rtl/alu_seq_core.sv
// Multi-cycle handshaked ALU: one opcode per transaction, iterative multiply and divide.
// Results and flags are registered and held until the consumer accepts them.
module alu_seq_core
   import alu_seq_core_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  OpCode        op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic [3:0]   flags,
   output logic         div_by_zero
);
   localparam int SHIFT_W = $clog2(N) + 1;
   localparam logic [SHIFT_W-1:0] MUL_LAST = SHIFT_W'(N - 1);
   localparam logic [SHIFT_W-1:0] MUL_END  = SHIFT_W'(N);
   localparam logic [N-1:0]       MIN_VAL  = {1'b1, {(N-1){1'b0}}};

   alu_state_t         state_reg;
   OpCode              op_reg;
   logic [N-1:0]       a_reg, b_reg, mplier_reg;
   logic [2*N-1:0]     acc_reg, mcand_reg;
   logic [SHIFT_W-1:0] cnt_reg;
   logic               in_ready_reg, out_valid_reg, dbz_reg;
   logic [N-1:0]       result_reg, result_hi_reg;
   alu_flags_t         flags_reg;

   logic               accept, in_is_div, div_start, div_done;
   logic [N-1:0]       a_mag, b_mag, q_mag, r_mag;
   logic [N:0]         sum, diff, lsh;
   logic signed [N:0]  rsh_src, rsh;
   logic [N-1:0]       exec_res, fix_q, fix_r, fix_res;
   logic               exec_dbz;
   alu_flags_t         exec_flags, mul_flags, fix_flags;
   logic [2*N-1:0]     mul_add, mul_sum;

   assign accept    = in_valid && in_ready_reg;
   assign in_is_div = (op == OP_DIV) || (op == OP_MOD);
   assign div_start = accept && in_is_div && (b != '0);
   assign a_mag     = a[N-1] ? ('0 - a) : a;
   assign b_mag     = b[N-1] ? ('0 - b) : b;

   div_iter #(.N(N)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (div_done),
      .quotient  (q_mag),
      .remainder (r_mag)
   );

   always_comb begin
      sum     = {1'b0, a_reg} + {1'b0, b_reg};
      diff    = {1'b0, a_reg} - {1'b0, b_reg};
      lsh     = {1'b0, a_reg} << b_reg;
      rsh_src = {a_reg, 1'b0};
      rsh     = rsh_src >>> b_reg;
      exec_res   = '0;
      exec_flags = '0;
      exec_dbz   = 1'b0;
      // EXEC only sees Div/Mod when the divisor was zero.
      case (op_reg)
         OP_ADD: begin
            exec_res     = sum[N-1:0];
            exec_flags.c = sum[N];
            exec_flags.v = (a_reg[N-1] == b_reg[N-1]) && (sum[N-1] != a_reg[N-1]);
         end
         OP_SUB: begin
            exec_res     = diff[N-1:0];
            exec_flags.c = diff[N];
            exec_flags.v = (a_reg[N-1] != b_reg[N-1]) && (diff[N-1] != a_reg[N-1]);
         end
         OP_DIV: begin
            exec_res = '1;
            exec_dbz = 1'b1;
         end
         OP_MOD: begin
            exec_res = a_reg;
            exec_dbz = 1'b1;
         end
         OP_AND: exec_res = a_reg & b_reg;
         OP_OR:  exec_res = a_reg | b_reg;
         OP_XOR: exec_res = a_reg ^ b_reg;
         OP_LSHIFT: begin
            exec_res     = lsh[N-1:0];
            exec_flags.c = lsh[N];
         end
         OP_RSHIFT: begin
            exec_res     = rsh[N:1];
            exec_flags.c = rsh[0];
         end
         default: exec_res = '0;
      endcase
      exec_flags.z  = (exec_res == '0);
      exec_flags.nf = exec_res[N-1];

      // Two's-complement multiplier: the MSB of b carries negative weight.
      mul_add = mplier_reg[0] ? mcand_reg : '0;
      mul_sum = (cnt_reg == MUL_LAST) ? (acc_reg - mul_add) : (acc_reg + mul_add);
      mul_flags.z  = (acc_reg[N-1:0] == '0);
      mul_flags.nf = acc_reg[N-1];
      mul_flags.v  = (acc_reg[2*N-1:N] != {N{acc_reg[N-1]}});
      mul_flags.c  = 1'b0;

      fix_q   = (a_reg[N-1] ^ b_reg[N-1]) ? ('0 - q_mag) : q_mag;
      fix_r   = a_reg[N-1] ? ('0 - r_mag) : r_mag;
      fix_res = (op_reg == OP_MOD) ? fix_r : fix_q;
      fix_flags.z  = (fix_res == '0);
      fix_flags.nf = fix_res[N-1];
      fix_flags.v  = (op_reg == OP_DIV) && (a_reg == MIN_VAL) && (b_reg == '1);
      fix_flags.c  = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         op_reg        <= OP_ADD;
         a_reg         <= '0;
         b_reg         <= '0;
         mplier_reg    <= '0;
         acc_reg       <= '0;
         mcand_reg     <= '0;
         cnt_reg       <= '0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         dbz_reg       <= 1'b0;
         result_reg    <= '0;
         result_hi_reg <= '0;
         flags_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               in_ready_reg <= 1'b1;
               if (accept) begin
                  in_ready_reg <= 1'b0;
                  a_reg        <= a;
                  b_reg        <= b;
                  op_reg       <= op;
                  acc_reg      <= '0;
                  mcand_reg    <= {{N{a[N-1]}}, a};
                  mplier_reg   <= b;
                  cnt_reg      <= '0;
                  if (op == OP_MULT)              state_reg <= MUL;
                  else if (in_is_div && b != '0) state_reg <= DIV;
                  else                           state_reg <= EXEC;
               end
            end
            EXEC: begin
               result_reg    <= exec_res;
               result_hi_reg <= '0;
               flags_reg     <= exec_flags;
               dbz_reg       <= exec_dbz;
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            MUL: begin
               if (cnt_reg == MUL_END) begin
                  result_reg    <= acc_reg[N-1:0];
                  result_hi_reg <= acc_reg[2*N-1:N];
                  flags_reg     <= mul_flags;
                  dbz_reg       <= 1'b0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  acc_reg    <= mul_sum;
                  mcand_reg  <= mcand_reg << 1;
                  mplier_reg <= mplier_reg >> 1;
                  cnt_reg    <= cnt_reg + SHIFT_W'(1);
               end
            end
            DIV: if (div_done) state_reg <= FIX;
            FIX: begin
               result_reg    <= fix_res;
               result_hi_reg <= '0;
               flags_reg     <= fix_flags;
               dbz_reg       <= 1'b0;
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_reg;
   assign out_valid   = out_valid_reg;
   assign result      = result_reg;
   assign result_hi   = result_hi_reg;
   assign flags       = flags_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed vector table, backpressure and reset-abort sequences,
// then random transactions against an integer-arithmetic reference model.
module tb_alu_seq_core;
   import alu_seq_core_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   OpCode        op = OP_ADD;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] result, result_hi;
   logic [3:0]   flags;
   logic         div_by_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq_core #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .result_hi   (result_hi),
      .flags       (flags),
      .div_by_zero (div_by_zero)
   );

   typedef struct {
      int         op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [7:0] hi;
      logic [3:0] fl;
      logic       dbz;
      int         lat;
   } vec_t;

   vec_t vecs[22];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int cyc;
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (in_ready !== 1'b1) check({name, " in_ready timeout"}, 64'(in_ready), 64'd1);
   endtask

   // Reference model: plain integer arithmetic on the signed/unsigned operand values.
   function automatic void model(input int opv, input logic [7:0] av, input logic [7:0] bv,
                                 output logic [7:0] res, output logic [7:0] hi,
                                 output logic [3:0] fl, output logic dbz, output int lat);
      int sa, sb, ua, ub, r;
      logic v, c;
      sa = int'($signed(av));
      sb = int'($signed(bv));
      ua = int'(av);
      ub = int'(bv);
      r = 0; v = 1'b0; c = 1'b0; dbz = 1'b0; lat = 1; hi = 8'h00;
      case (opv)
         0: begin r = ua + ub; c = (r > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
         1: begin r = ua - ub; c = (ua < ub); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
         2: begin r = sa * sb; hi = r[15:8]; v = (r > 127) || (r < -128); lat = 9; end
         3: if (sb == 0) begin r = 255; dbz = 1'b1; end
            else begin r = sa / sb; v = (r > 127); lat = 10; end
         4: if (sb == 0) begin r = ua; dbz = 1'b1; end
            else begin r = sa % sb; lat = 10; end
         5: r = ua & ub;
         6: r = ua | ub;
         7: r = ua ^ ub;
         8: if (ub > 8) r = 0;
            else begin r = ua << ub; c = (ub != 0) && (((ua >> (8 - ub)) & 1) != 0); end
         9: if (ub == 0) r = ua;
            else if (ub >= 8) begin r = (sa < 0) ? -1 : 0; c = (sa < 0); end
            else begin r = sa >>> ub; c = ((ua >> (ub - 1)) & 1) != 0; end
         default: r = 0;
      endcase
      res = r[7:0];
      fl  = {res == 8'h00, res[7], v, c};
   endfunction

   task automatic run_txn(input string name, input int opv, input logic [7:0] av,
                          input logic [7:0] bv, input int hold,
                          input logic [7:0] e_res, input logic [7:0] e_hi,
                          input logic [3:0] e_fl, input logic e_dbz, input int e_lat);
      int lat;
      logic [20:0] snap;
      wait_ready(name);
      in_valid = 1'b1;
      a  = av;
      b  = bv;
      op = OpCode'(4'(opv));
      @(posedge clk); #1;
      // Scramble inputs after accept; the captured operands must be used.
      in_valid = 1'b0;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = OpCode'(4'($urandom_range(0, 15)));
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("txn %s op=%0d a=%h b=%h -> res=%h hi=%h fl=%b dbz=%b lat=%0d (exp %h %h %b %b %0d)",
               name, opv, av, bv, result, result_hi, flags, div_by_zero, lat,
               e_res, e_hi, e_fl, e_dbz, e_lat);
      check(name, {35'd0, result, result_hi, flags, div_by_zero, lat[7:0]},
            {35'd0, e_res, e_hi, e_fl, e_dbz, e_lat[7:0]});
      snap = {result, result_hi, flags, div_by_zero};
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, " hold"}, {41'd0, out_valid, in_ready, result, result_hi, flags, div_by_zero},
               {41'd0, 1'b1, 1'b0, snap});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " release"}, {62'd0, out_valid, in_ready}, 64'b01);
   endtask

   initial begin
      logic [7:0] m_res, m_hi, ra, rb;
      logic [3:0] m_fl;
      logic       m_dbz;
      int         m_lat, ropv;

      vecs[0]  = '{0, 8'd100, 8'd50, 8'h96, 8'h00, 4'b0110, 1'b0, 1};
      vecs[1]  = '{2, 8'hFD,  8'h05, 8'hF1, 8'hFF, 4'b0100, 1'b0, 9};
      vecs[2]  = '{2, 8'h10,  8'h10, 8'h00, 8'h01, 4'b1010, 1'b0, 9};
      vecs[3]  = '{3, 8'hF9,  8'h02, 8'hFD, 8'h00, 4'b0100, 1'b0, 10};
      vecs[4]  = '{4, 8'hF9,  8'h02, 8'hFF, 8'h00, 4'b0100, 1'b0, 10};
      vecs[5]  = '{3, 8'h80,  8'hFF, 8'h80, 8'h00, 4'b0110, 1'b0, 10};
      vecs[6]  = '{4, 8'h80,  8'hFF, 8'h00, 8'h00, 4'b1000, 1'b0, 10};
      vecs[7]  = '{3, 8'h05,  8'h00, 8'hFF, 8'h00, 4'b0100, 1'b1, 1};
      vecs[8]  = '{4, 8'h05,  8'h00, 8'h05, 8'h00, 4'b0000, 1'b1, 1};
      vecs[9]  = '{1, 8'h03,  8'h05, 8'hFE, 8'h00, 4'b0101, 1'b0, 1};
      vecs[10] = '{8, 8'h81,  8'h01, 8'h02, 8'h00, 4'b0001, 1'b0, 1};
      vecs[11] = '{9, 8'h81,  8'h01, 8'hC0, 8'h00, 4'b0101, 1'b0, 1};
      vecs[12] = '{9, 8'h80,  8'h09, 8'hFF, 8'h00, 4'b0101, 1'b0, 1};
      vecs[13] = '{8, 8'h01,  8'h08, 8'h00, 8'h00, 4'b1001, 1'b0, 1};
      vecs[14] = '{8, 8'h0F,  8'h00, 8'h0F, 8'h00, 4'b0000, 1'b0, 1};
      vecs[15] = '{12, 8'h05, 8'h03, 8'h00, 8'h00, 4'b1000, 1'b0, 1};
      vecs[16] = '{0, 8'hFF,  8'h01, 8'h00, 8'h00, 4'b1001, 1'b0, 1};
      vecs[17] = '{1, 8'h80,  8'h01, 8'h7F, 8'h00, 4'b0010, 1'b0, 1};
      vecs[18] = '{5, 8'hF0,  8'h3C, 8'h30, 8'h00, 4'b0000, 1'b0, 1};
      vecs[19] = '{7, 8'h5A,  8'h5A, 8'h00, 8'h00, 4'b1000, 1'b0, 1};
      vecs[20] = '{3, 8'h64,  8'hF9, 8'hF2, 8'h00, 4'b0100, 1'b0, 10};
      vecs[21] = '{4, 8'h64,  8'hF9, 8'h02, 8'h00, 4'b0000, 1'b0, 10};

      #12;
      check("reset_state", {42'd0, in_ready, out_valid, result, result_hi, flags, div_by_zero}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
                 vecs[i].res, vecs[i].hi, vecs[i].fl, vecs[i].dbz, vecs[i].lat);

      run_txn("backpressure", 0, 8'd100, 8'd50, 5, 8'h96, 8'h00, 4'b0110, 1'b0, 1);

      // Abort a divide at iteration 4 with reset.
      wait_ready("reset_div");
      in_valid = 1'b1; a = 8'd100; b = 8'd7; op = OP_DIV;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_mid_div", {42'd0, in_ready, out_valid, result, result_hi, flags, div_by_zero}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", {62'd0, in_ready, out_valid}, 64'd0);
      rst_n = 1'b1;
      run_txn("after_reset_sub", 1, 8'h03, 8'h05, 0, 8'hFE, 8'h00, 4'b0101, 1'b0, 1);

      for (int i = 0; i < 150; i++) begin
         ropv = $urandom_range(0, 10);
         if (ropv == 10) ropv = $urandom_range(10, 15);
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (ropv == 8 || ropv == 9) rb = 8'($urandom_range(0, 11));
         if ((ropv == 3 || ropv == 4) && $urandom_range(0, 5) == 0) rb = 8'h00;
         if ($urandom_range(0, 9) == 0) ra = 8'h80;
         model(ropv, ra, rb, m_res, m_hi, m_fl, m_dbz, m_lat);
         run_txn($sformatf("rnd%0d", i), ropv, ra, rb, $urandom_range(0, 2),
                 m_res, m_hi, m_fl, m_dbz, m_lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
